seg_digit_driver: RTL and testbench

- Downstream consumer of the 4-digit anode ring counter on the Basys3 seven-segment display.
- Takes the one-cold anode select pattern and a packed hex value, and drives registered, active-low anode, segment and decimal-point pins.
- Double-buffers the displayed value so updates land only at frame boundaries, which prevents torn digits.
- Inserts a ghosting dead-time on every digit change.

---
 rtl/seg_digit_driver.sv | 124 ++++++++++++
 tb/tb_seg_digit_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_digit_driver.sv
// Registered active-low anode/segment driver for a multiplexed seven-segment display,
// with frame-aligned double buffering of the shown value and an anode dead-time.
module seg_digit_driver #(
    parameter  int NUM_DIGITS   = 4,
    parameter  int BLANK_CYCLES = 8,
    localparam int CNT_W        = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic [NUM_DIGITS-1:0]   anode_sel_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    load_i,
    input  logic                    lz_blank_en_i,
    output logic                    pending_o,
    output logic [NUM_DIGITS-1:0]   anode_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o
);

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    logic [NUM_DIGITS-1:0]   sel_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] staged_val_q, active_val_q, val_d;
    logic [NUM_DIGITS-1:0]   staged_dp_q, active_dp_q, dpa_d;
    logic                    pending_q;

    logic                    change, commit, blank, sel_ok, zeros_up, lz_hit;
    logic [IDX_W-1:0]        idx;
    logic [3:0]              nib;
    logic [NUM_DIGITS-1:0]   anode_d;
    logic [6:0]              seg_d;
    logic                    dp_d;

    // Decode from the post-commit value so the first digit of a new frame is never stale.
    always_comb begin
        change = (anode_sel_i != sel_q);
        commit = change && !anode_sel_i[0] && pending_q;

        cnt_d = cnt_q;
        if (change)
            cnt_d = CNT_W'(BLANK_CYCLES);
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
        blank = (cnt_d != '0);

        val_d  = commit ? staged_val_q : active_val_q;
        dpa_d  = commit ? staged_dp_q  : active_dp_q;
        sel_ok = $onehot(~anode_sel_i);

        idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (!anode_sel_i[k]) idx = IDX_W'(k);
        nib = val_d[4*idx +: 4];

        zeros_up = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (k >= int'(idx) && val_d[4*k +: 4] != 4'h0) zeros_up = 1'b0;
        lz_hit = lz_blank_en_i && (idx != '0) && zeros_up;

        anode_d = '1;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        if (!blank && sel_ok) begin
            anode_d = anode_sel_i;
            seg_d   = lz_hit ? 7'h7F : hex7(nib);
            dp_d    = ~dpa_d[idx];
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sel_q        <= '1;
            cnt_q        <= '0;
            staged_val_q <= '0;
            staged_dp_q  <= '0;
            active_val_q <= '0;
            active_dp_q  <= '0;
            pending_q    <= 1'b0;
            anode_o      <= '1;
            seg_o        <= 7'h7F;
            dp_o         <= 1'b1;
        end else begin
            sel_q        <= anode_sel_i;
            cnt_q        <= cnt_d;
            active_val_q <= val_d;
            active_dp_q  <= dpa_d;
            if (load_i) begin
                staged_val_q <= value_i;
                staged_dp_q  <= dp_i;
                pending_q    <= 1'b1;
            end else if (commit) begin
                pending_q    <= 1'b0;
            end
            anode_o      <= anode_d;
            seg_o        <= seg_d;
            dp_o         <= dp_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: tb/tb_seg_digit_driver.sv
// Bench for seg_digit_driver: one instance with dead-time 2, one with dead-time 0,
// sharing stimulus; expectations are queued per cycle and checked by a monitor.
module tb_seg_digit_driver;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic [3:0]  anode_sel;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        lz;

  logic        pend_a, pend_b, dp_a, dp_b;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;

  always #5 clk = ~clk;

  seg_digit_driver #(.NUM_DIGITS(4), .BLANK_CYCLES(2)) dut_a (
    .clk_i(clk), .reset_ni(reset_ni), .anode_sel_i(anode_sel), .value_i(value),
    .dp_i(dp), .load_i(load), .lz_blank_en_i(lz), .pending_o(pend_a),
    .anode_o(an_a), .seg_o(seg_a), .dp_o(dp_a));

  seg_digit_driver #(.NUM_DIGITS(4), .BLANK_CYCLES(0)) dut_b (
    .clk_i(clk), .reset_ni(reset_ni), .anode_sel_i(anode_sel), .value_i(value),
    .dp_i(dp), .load_i(load), .lz_blank_en_i(lz), .pending_o(pend_b),
    .anode_o(an_b), .seg_o(seg_b), .dp_o(dp_b));

  typedef struct {
    int         cyc;
    bit         dut;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       pend;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  exp_t       e;
  logic [3:0] g_an;
  logic [6:0] g_seg;
  logic       g_dp, g_pend;

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        e = q[i];
        q.delete(i);
        n_cmp++;
        if (e.dut) begin
          g_an = an_b; g_seg = seg_b; g_dp = dp_b; g_pend = pend_b;
        end else begin
          g_an = an_a; g_seg = seg_a; g_dp = dp_a; g_pend = pend_a;
        end
        if (e.cyc != cyc || g_an !== e.an || g_seg !== e.seg ||
            g_dp !== e.dp || g_pend !== e.pend) begin
          n_bad++;
          $display("FAIL %s (dut %s, cyc %0d): got an=%h seg=%h dp=%b pend=%b, want an=%h seg=%h dp=%b pend=%b",
                   e.name, e.dut ? "b" : "a", cyc, g_an, g_seg, g_dp, g_pend,
                   e.an, e.seg, e.dp, e.pend);
        end
      end
    end
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL timeout: expired wait, stimulus did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input bit d, input int dl, input logic [3:0] an,
                           input logic [6:0] sg, input logic dpv, input logic pd,
                           input string nm);
    exp_t x;
    x.cyc = cyc + dl; x.dut = d; x.an = an; x.seg = sg;
    x.dp = dpv; x.pend = pd; x.name = nm;
    q.push_back(x);
  endtask

  localparam bit A = 1'b0;
  localparam bit B = 1'b1;

  initial begin
    reset_ni = 1'b0; anode_sel = 4'hF; value = '0; dp = '0; load = 1'b0; lz = 1'b0;
    step(2);
    expect_at(A, 0, 4'hF, 7'h7F, 1'b1, 1'b0, "reset_a");
    expect_at(B, 0, 4'hF, 7'h7F, 1'b1, 1'b0, "reset_b");
    reset_ni = 1'b1;
    step(1);

    // load then scan
    value = 16'h12AF; dp = 4'b0100; load = 1'b1;
    expect_at(A, 1, 4'hF, 7'h7F, 1'b1, 1'b1, "load_pending");
    step(1);
    load = 1'b0; anode_sel = 4'b1110;
    expect_at(A, 1, 4'hF, 7'h7F, 1'b1, 1'b0, "dark1");
    expect_at(A, 2, 4'hF, 7'h7F, 1'b1, 1'b0, "dark2");
    expect_at(A, 3, 4'hE, 7'h0E, 1'b1, 1'b0, "dig0_F");
    step(3);
    anode_sel = 4'b1011;
    expect_at(A, 3, 4'hB, 7'h24, 1'b0, 1'b0, "dig2_2_dp");
    step(3);

    // mid-frame load
    value = 16'h0000; dp = 4'b0000; load = 1'b1;
    expect_at(A, 1, 4'hB, 7'h24, 1'b0, 1'b1, "midload_hold");
    step(1);
    load = 1'b0; anode_sel = 4'b0111;
    expect_at(A, 3, 4'h7, 7'h79, 1'b1, 1'b1, "d3_old_value");
    expect_at(B, 1, 4'h7, 7'h79, 1'b1, 1'b1, "b_d3_old_value");
    step(3);
    anode_sel = 4'b1110;
    expect_at(A, 1, 4'hF, 7'h7F, 1'b1, 1'b0, "commit_dark");
    expect_at(A, 3, 4'hE, 7'h40, 1'b1, 1'b0, "d0_new_value");
    step(3);

    // simultaneous load and frame boundary
    value = 16'h1111; load = 1'b1;
    expect_at(A, 1, 4'hE, 7'h40, 1'b1, 1'b1, "stage_1111");
    step(1);
    load = 1'b0; anode_sel = 4'b1101;
    expect_at(A, 3, 4'hD, 7'h40, 1'b1, 1'b1, "d1_still_0");
    expect_at(B, 1, 4'hD, 7'h40, 1'b1, 1'b1, "b_d1_still_0");
    step(3);
    anode_sel = 4'b1110; value = 16'h2222; load = 1'b1;
    expect_at(A, 1, 4'hF, 7'h7F, 1'b1, 1'b1, "simul_pending");
    step(1);
    load = 1'b0;
    expect_at(A, 2, 4'hE, 7'h79, 1'b1, 1'b1, "frame_1s_d0");
    step(2);
    anode_sel = 4'b1101;
    expect_at(A, 3, 4'hD, 7'h79, 1'b1, 1'b1, "frame_1s_d1");
    expect_at(B, 1, 4'hD, 7'h79, 1'b1, 1'b1, "b_frame_1s_d1");
    step(3);
    anode_sel = 4'b1110;
    expect_at(A, 3, 4'hE, 7'h24, 1'b1, 1'b0, "frame_2s_d0");
    step(3);

    // leading-zero blanking
    value = 16'h0050; lz = 1'b1; load = 1'b1;
    expect_at(A, 1, 4'hE, 7'h24, 1'b1, 1'b1, "stage_0050");
    step(1);
    load = 1'b0; anode_sel = 4'b0111;
    expect_at(A, 3, 4'h7, 7'h24, 1'b1, 1'b1, "d3_before_commit");
    step(3);
    anode_sel = 4'b1110;
    expect_at(A, 3, 4'hE, 7'h40, 1'b1, 1'b0, "lz_d0_kept");
    step(3);
    anode_sel = 4'b1101;
    expect_at(A, 3, 4'hD, 7'h12, 1'b1, 1'b0, "lz_d1_5");
    expect_at(B, 1, 4'hD, 7'h12, 1'b1, 1'b0, "b_lz_d1_5");
    step(3);
    anode_sel = 4'b1011;
    expect_at(A, 3, 4'hB, 7'h7F, 1'b1, 1'b0, "lz_d2_blank");
    expect_at(B, 1, 4'hB, 7'h7F, 1'b1, 1'b0, "b_lz_d2_blank");
    step(3);
    anode_sel = 4'b0111;
    expect_at(A, 3, 4'h7, 7'h7F, 1'b1, 1'b0, "lz_d3_blank");
    step(3);
    lz = 1'b0;
    expect_at(A, 1, 4'h7, 7'h40, 1'b1, 1'b0, "nolz_d3_zero");
    expect_at(B, 1, 4'h7, 7'h40, 1'b1, 1'b0, "b_nolz_d3_zero");
    step(1);

    // invalid select, then no dead-time on the zero-blank instance
    anode_sel = 4'b1100;
    expect_at(B, 1, 4'hF, 7'h7F, 1'b1, 1'b0, "b_invalid1");
    expect_at(B, 3, 4'hF, 7'h7F, 1'b1, 1'b0, "b_invalid3");
    expect_at(A, 3, 4'hF, 7'h7F, 1'b1, 1'b0, "a_invalid3");
    step(3);
    anode_sel = 4'b1101;
    expect_at(B, 1, 4'hD, 7'h12, 1'b1, 1'b0, "b_no_deadtime");
    expect_at(A, 1, 4'hF, 7'h7F, 1'b1, 1'b0, "a_deadtime");
    expect_at(A, 3, 4'hD, 7'h12, 1'b1, 1'b0, "a_after_deadtime");
    step(3);

    // asynchronous reset mid-display with a staged value pending
    value = 16'h1234; load = 1'b1;
    step(1);
    load = 1'b0; reset_ni = 1'b0;
    #1;
    n_cmp++;
    if (an_a !== 4'hF || seg_a !== 7'h7F || dp_a !== 1'b1 || pend_a !== 1'b0 ||
        an_b !== 4'hF || seg_b !== 7'h7F || dp_b !== 1'b1 || pend_b !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset_immediate: a an=%h seg=%h dp=%b pend=%b, b an=%h seg=%h dp=%b pend=%b",
               an_a, seg_a, dp_a, pend_a, an_b, seg_b, dp_b, pend_b);
    end
    expect_at(A, 0, 4'hF, 7'h7F, 1'b1, 1'b0, "async_reset_a");
    expect_at(B, 0, 4'hF, 7'h7F, 1'b1, 1'b0, "async_reset_b");
    step(1);
    reset_ni = 1'b1; anode_sel = 4'b1110;
    expect_at(A, 1, 4'hF, 7'h7F, 1'b1, 1'b0, "post_reset_dark");
    expect_at(A, 3, 4'hE, 7'h40, 1'b1, 1'b0, "staged_lost_a");
    expect_at(B, 1, 4'hE, 7'h40, 1'b1, 1'b0, "staged_lost_b");
    step(4);

    if (q.size() != 0) begin
      n_bad += q.size();
      foreach (q[i])
        $display("FAIL %s: expectation for cyc %0d never checked", q[i].name, q[i].cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
